clksel_initiator: RTL

Initiator side of the clock-select val/rdy channel that a clock switcher (`clksel_val`/`clksel_rdy`/`clksel_msg`) responds to. It accepts clock-select commands from the configuration fabric and drops redundant ones. It drives each real switch request to the switcher under val/rdy handshake, then enforces a settle window before accepting the next command. It sits in the always-on clock domain next to each rgals-wrapped tile and tracks the tile's current clock selection and switch count.

---
 rtl/clksel_initiator_pkg.sv | 18 +
 rtl/clksel_down_ctr.sv | 31 +++
 rtl/clksel_initiator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/clksel_initiator_pkg.sv
// clksel_initiator_pkg: shared state encoding and clock-select constants for the
// clock-select initiator.
`default_nettype none

package clksel_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SETTLE = 2'd2
  } clksel_state_t;

  localparam logic CLKSEL_CLK1 = 1'b0;
  localparam logic CLKSEL_CLK2 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/clksel_down_ctr.sv
// clksel_down_ctr: loadable down counter with zero flag; saturates at zero.
`default_nettype none

module clksel_down_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/clksel_initiator.sv
// clksel_initiator: forwards non-redundant clock-select commands to the switcher
// over val/rdy, then holds off for a settle window. Macro: CLKSEL_INITIATOR_TIMEOUT_EN.
`default_nettype none

module clksel_initiator
  import clksel_initiator_pkg::*;
#(
  parameter int p_settle    = 4,
  parameter int p_timeout   = 16,
  parameter int p_cnt_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_val,
  output logic                   cmd_rdy,
  input  logic                   cmd_msg,
  output logic                   clksel_val,
  input  logic                   clksel_rdy,
  output logic                   clksel_msg,
  output logic                   sel_cur,
  output logic                   busy,
  output logic [p_cnt_width-1:0] nswitch,
  output logic                   err
);

  localparam int SETTLE_W = (p_settle > 1) ? $clog2(p_settle) : 1;

  if (p_settle < 1 || p_timeout < 1 || p_cnt_width < 1) begin : g_bad_param
    $error("clksel_initiator: p_settle, p_timeout and p_cnt_width must be >= 1");
  end

  clksel_state_t          state_q, state_d;
  logic                   sel_cur_q, sel_cur_d;
  logic                   msg_q, msg_d;
  logic                   val_q, val_d;
  logic                   busy_q, busy_d;
  logic [p_cnt_width-1:0] nswitch_q, nswitch_d;

  logic cmd_xfer;
  logic clksel_xfer;
  logic settle_load;
  logic settle_dec;
  logic settle_zero;

  // cmd_rdy depends only on registered state (and reset), never on clksel_rdy.
  assign cmd_rdy     = (state_q == IDLE) && !reset;
  assign cmd_xfer    = cmd_val && cmd_rdy;
  assign clksel_xfer = val_q && clksel_rdy;

  clksel_down_ctr #(
    .WIDTH(SETTLE_W)
  ) u_settle_ctr (
    .clk       (clk),
    .rst_i     (reset),
    .load_i    (settle_load),
    .load_val_i(SETTLE_W'(p_settle - 1)),
    .dec_i     (settle_dec),
    .zero_o    (settle_zero)
  );

`ifdef CLKSEL_INITIATOR_TIMEOUT_EN
  localparam int TMO_W = (p_timeout > 1) ? $clog2(p_timeout) : 1;

  logic tmo_load;
  logic tmo_dec;
  logic tmo_zero;
  logic err_q, err_d;

  clksel_down_ctr #(
    .WIDTH(TMO_W)
  ) u_tmo_ctr (
    .clk       (clk),
    .rst_i     (reset),
    .load_i    (tmo_load),
    .load_val_i(TMO_W'(p_timeout - 1)),
    .dec_i     (tmo_dec),
    .zero_o    (tmo_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sel_cur_d   = sel_cur_q;
    msg_d       = msg_q;
    nswitch_d   = nswitch_q;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
`ifdef CLKSEL_INITIATOR_TIMEOUT_EN
    tmo_load    = 1'b0;
    tmo_dec     = 1'b0;
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        // Redundant commands are consumed here without leaving IDLE.
        if (cmd_xfer && (cmd_msg != sel_cur_q)) begin
          msg_d   = cmd_msg;
          state_d = REQ;
`ifdef CLKSEL_INITIATOR_TIMEOUT_EN
          tmo_load = 1'b1;
`endif
        end
      end
      REQ: begin
        if (clksel_xfer) begin
          sel_cur_d   = msg_q;
          nswitch_d   = nswitch_q + p_cnt_width'(1);
          settle_load = 1'b1;
          state_d     = SETTLE;
        end
`ifdef CLKSEL_INITIATOR_TIMEOUT_EN
        else if (tmo_zero) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_dec = 1'b1;
        end
`endif
      end
      SETTLE: begin
        if (settle_zero) begin
          state_d = IDLE;
        end else begin
          settle_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    val_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_cur_q <= CLKSEL_CLK1;
      msg_q     <= CLKSEL_CLK1;
      val_q     <= 1'b0;
      busy_q    <= 1'b0;
      nswitch_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_cur_q <= sel_cur_d;
      msg_q     <= msg_d;
      val_q     <= val_d;
      busy_q    <= busy_d;
      nswitch_q <= nswitch_d;
    end
  end

  assign clksel_val = val_q;
  assign clksel_msg = msg_q;
  assign sel_cur    = sel_cur_q;
  assign busy       = busy_q;
  assign nswitch    = nswitch_q;

endmodule

`default_nettype wire
